i2c_master_core: RTL and testbench

- Single-byte I2C master engine: generates START, 7-bit address + R/W, one data byte (write or read), ACK handling, and STOP.
- Sits between a register/APB front end (enable, address, data, rw) and open-drain SDA/SCL pads.
- Outputs are drive enables: 1 = release (pulled high), 0 = pull low.
- Inputs sda_i/scl_i are the resolved pad levels.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_master_core_clk_gen.sv | 52 +++++
 rtl/i2c_master_core.sv | 155 +++++++++++++++
 tb/tb_i2c_master_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the single-byte I2C master: FSM states, bit counter width,
// and the pad-drive pattern for each state/quarter.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, WRITE, ACK_D, READ, MACK, STOP
    } state_e;

    localparam int BIT_CNT_W = 3;

    // Returns {sda, scl} drive for a given state, quarter phase and outgoing bit.
    function automatic logic [1:0] line_drive(input state_e st, input logic [1:0] ph,
                                              input logic bit_val);
        logic [1:0] drv;
        drv = 2'b11;
        unique case (st)
            IDLE:        drv = 2'b11;
            START:       drv = ph[1] ? 2'b01 : 2'b11;
            STOP:        drv = (ph == 2'd0) ? 2'b00 : (ph == 2'd1) ? 2'b01 : 2'b11;
            ADDR, WRITE: drv = {bit_val, ph[1]};
            default:     drv = {1'b1, ph[1]};
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/i2c_master_core_clk_gen.sv
// Quarter-period tick generator with SCL stretch hold and q0..q3 phase output.
module i2c_clk_gen #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       scl_o,
    input  logic       scl_i,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       phase_q, phase_d;
    logic             hold;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hold    = phase_q[1] && scl_o && !scl_i;
        tick    = !clr && !hold && (cnt_q == CNT_W'(DIV - 1));
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clr) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (!hold) begin
            if (tick) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/i2c_master_core.sv
// Single-byte I2C master: START, address+R/W, one data byte, ACK handling, STOP.
// rst_n is a synchronous reset that is active HIGH.
module i2c_master_core
    import i2c_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] slave_address,
    input  logic [7:0] data_in,
    input  logic       rw,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_o,
    output logic       scl_o,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    state_e                 state_q, state_d;
    logic [7:0]             sr_q, sr_d, data_q, data_d, data_out_q, data_out_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   rw_q, rw_d, ack_q, ack_d;
    logic                   sda_q, sda_d, scl_q, scl_d;
    logic                   busy_q, busy_d, done_q, done_d, ack_err_q, ack_err_d;
    logic                   tick, step_end, sample;
    logic [1:0]             phase, phase_n;

    i2c_clk_gen #(.DIV(DIV)) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == IDLE),
        .scl_o (scl_q),
        .scl_i (scl_i),
        .tick  (tick),
        .phase (phase)
    );

    always_comb begin
        phase_n    = tick ? phase + 2'd1 : phase;
        step_end   = tick && (phase == 2'd3);
        sample     = tick && (phase == 2'd2);
        state_d    = state_q;
        sr_d       = sr_q;
        data_d     = data_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = ack_err_q;
        unique case (state_q)
            IDLE: if (enable) begin
                state_d   = START;
                sr_d      = {slave_address, rw};
                rw_d      = rw;
                data_d    = data_in;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
            end
            START: if (step_end) begin
                state_d   = ADDR;
                bit_cnt_d = '0;
            end
            ADDR, WRITE: if (step_end) begin
                sr_d      = {sr_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BIT_CNT_W'(7)) state_d = (state_q == ADDR) ? ACK_A : ACK_D;
            end
            ACK_A: begin
                if (sample) ack_d = sda_i;
                if (step_end) begin
                    if (ack_q) begin
                        ack_err_d = 1'b1;
                        state_d   = STOP;
                    end else if (rw_q) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                        sr_d    = data_q;
                    end
                end
            end
            ACK_D: begin
                if (sample) ack_d = sda_i;
                if (step_end) begin
                    if (ack_q) ack_err_d = 1'b1;
                    state_d = STOP;
                end
            end
            READ: begin
                if (sample) sr_d = {sr_q[6:0], sda_i};
                if (step_end) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(7)) state_d = MACK;
                end
            end
            MACK: if (step_end) begin
                data_out_d = sr_q;
                state_d    = STOP;
            end
            STOP: if (step_end) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Pads are registered from the upcoming state/phase so SDA moves only at q0.
        {sda_d, scl_d} = line_drive(state_d, phase_n, sr_d[7]);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b1;
            sda_q      <= 1'b1;
            scl_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            data_q     <= data_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            sda_q      <= sda_d;
            scl_q      <= scl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign sda_o    = sda_q;
    assign scl_o    = scl_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ack_err  = ack_err_q;

endmodule

// File: tb/tb_i2c_master_core.sv
// Self-checking bench: bus monitor + slave model, reference frames built from the I2C rules.
module tb_i2c_master_core;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n, enable, rw;
    logic [6:0] slave_address;
    logic [7:0] data_in;
    logic       sda_i, scl_i, sda_o, scl_o, busy, done, ack_err;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    // Slave model configuration and bus monitor state.
    bit         s_rw, s_ack_a, s_ack_d;
    logic [7:0] s_rd_byte;
    logic       slave_low = 1'b0;
    int         stretch_cnt = 0;
    int         stretch_bit = -1;
    bit         bits_q[$];
    bit         frame_q[$];
    int         frames = 0;
    int         hlen[32];
    int         hcnt = 0;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] exp_dout = 8'h00;

    assign sda_i = sda_o & ~slave_low;
    assign scl_i = scl_o & (stretch_cnt == 0);

    i2c_master_core #(.DIV(DIV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .slave_address (slave_address),
        .data_in       (data_in),
        .rw            (rw),
        .sda_i         (sda_i),
        .scl_i         (scl_i),
        .sda_o         (sda_o),
        .scl_o         (scl_o),
        .data_out      (data_out),
        .busy          (busy),
        .done          (done),
        .ack_err       (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave pulls SDA low for bit index idx (bit 0 = first address bit after START).
    function automatic logic slave_drive(input int idx);
        if (idx == 8) return s_ack_a;
        if (!s_rw && idx == 17) return s_ack_d;
        if (s_rw && s_ack_a && idx >= 9 && idx <= 16) return ~s_rd_byte[16 - idx];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        logic cur_sda, cur_scl;
        if (stretch_cnt > 0) stretch_cnt--;
        cur_sda = sda_i;
        cur_scl = scl_o;
        if (prev_scl && cur_scl) begin
            if (prev_sda && !cur_sda) begin
                bits_q.delete();
                slave_low = 1'b0;
            end else if (!prev_sda && cur_sda) begin
                frame_q = bits_q;
                if (frame_q.size() > 0) void'(frame_q.pop_back());
                frames++;
            end
            hcnt++;
        end else if (!prev_scl && cur_scl) begin
            bits_q.push_back(cur_sda);
            hcnt = 1;
            if (bits_q.size() - 1 == stretch_bit) stretch_cnt = 20;
        end else if (prev_scl && !cur_scl) begin
            if (bits_q.size() > 0 && bits_q.size() <= 32) hlen[bits_q.size() - 1] = hcnt;
            slave_low = slave_drive(bits_q.size());
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input bit r,
                           input bit aa, input bit ad, input logic [7:0] rdb,
                           input int sbit, input bit keep);
        bit          exp_q[$];
        int          cyc, f0, exp_len;
        logic [31:0] got_w, exp_w;
        s_rw = r; s_ack_a = aa; s_ack_d = ad; s_rd_byte = rdb; stretch_bit = sbit;
        slave_address = a; data_in = d; rw = r; enable = 1'b1;
        for (int i = 6; i >= 0; i--) exp_q.push_back(a[i]);
        exp_q.push_back(r);
        exp_q.push_back(!aa);
        if (aa) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(r ? rdb[i] : d[i]);
            exp_q.push_back(r ? 1'b1 : !ad);
        end
        if (aa && r) exp_dout = rdb;
        exp_len = 4 * DIV * (exp_q.size() + 2) + ((sbit >= 0) ? 20 : 0);

        cyc = 0;
        while (!busy && cyc < 100) begin @(negedge clk); cyc++; end
        check("busy_rise", busy, 1);
        f0 = frames;
        cyc = 0;
        while (!done && cyc < 4000) begin @(negedge clk); cyc++; end
        check("done_seen", done, 1);
        check("txn_clocks", cyc, exp_len);
        check("busy_at_done", busy, 0);
        check("ack_err", ack_err, (!aa || (!r && !ad)) ? 1 : 0);
        check("data_out", data_out, exp_dout);
        check("frame_count", frames, f0 + 1);
        check("frame_len", frame_q.size(), exp_q.size());
        got_w = '0; exp_w = '0;
        foreach (frame_q[i]) got_w = {got_w[30:0], frame_q[i]};
        foreach (exp_q[i]) exp_w = {exp_w[30:0], exp_q[i]};
        check("frame_bits", got_w, exp_w);
        if (sbit >= 0) begin
            check("stretch_high", hlen[sbit], 2 * DIV + 20);
            check("normal_high", hlen[sbit - 1], 2 * DIV);
        end
        if (!keep) enable = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("sda_idle", sda_o, 1);
        if (keep) check("back_to_back_busy", busy, 1);
        else      check("scl_idle", scl_o, 1);
        stretch_bit = -1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  seen_done;
        rst_n = 1'b1; enable = 1'b0; rw = 1'b0; slave_address = '0; data_in = '0;
        repeat (2) @(negedge clk);
        check("rst_sda", sda_o, 1);
        check("rst_scl", scl_o, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_data_out", data_out, 0);
        rst_n = 1'b0;
        @(negedge clk);

        // Address NACK, held enable repeats the transaction.
        run_txn(7'b1101011, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, -1, 1'b1);
        run_txn(7'b1101011, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, -1, 1'b0);
        repeat (3) @(negedge clk);

        run_txn(7'h3C, 8'hAA, 1'b0, 1'b1, 1'b1, 8'h00, -1, 1'b0);
        run_txn(7'h51, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5A, -1, 1'b0);
        run_txn(7'h2E, 8'hC3, 1'b0, 1'b1, 1'b0, 8'h00, -1, 1'b0);
        run_txn(7'h6A, 8'h3B, 1'b0, 1'b1, 1'b1, 8'h00, 3, 1'b0);

        for (int n = 0; n < 12; n++) begin
            run_txn(7'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                    1'($urandom), 8'($urandom), -1, 1'b0);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // Reset in the middle of the data byte of a write.
        s_rw = 1'b0; s_ack_a = 1'b1; s_ack_d = 1'b1;
        slave_address = 7'h12; data_in = 8'h99; rw = 1'b0; enable = 1'b1;
        cyc = 0;
        while (bits_q.size() < 11 && cyc < 4000) begin @(negedge clk); cyc++; end
        check("reached_write", (bits_q.size() >= 11) ? 1 : 0, 1);
        rst_n = 1'b1; enable = 1'b0;
        @(negedge clk);
        check("midrst_sda", sda_o, 1);
        check("midrst_scl", scl_o, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_data_out", data_out, 0);
        rst_n = 1'b0;
        seen_done = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (done || busy || !sda_o || !scl_o) seen_done = 1'b1;
        end
        check("midrst_quiet", seen_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
